// File: rtl/receive_pixel_pkg.sv
// Shared types and constants for the FPGA-to-NANO pixel link receiver.
package pixel_uart_pkg;

    localparam int unsigned PIXEL_W = 12;
    localparam int unsigned ADDR_W  = 17;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [0:0] {
        HI,
        LO
    } asm_phase_t;

endpackage

// File: rtl/receive_pixel_if.sv
// Pixel output stream of receive_pixel: pixel + frame address on a valid/ready handshake.
interface receive_pixel_if;
    import pixel_uart_pkg::*;

    logic [PIXEL_W-1:0] pixel;
    logic [ADDR_W-1:0]  pixel_addr;
    logic               valid_out;
    logic               ready_in;
    logic               frame_done;

    modport master (
        output pixel,
        output pixel_addr,
        output valid_out,
        output frame_done,
        input  ready_in
    );

    modport slave (
        input  pixel,
        input  pixel_addr,
        input  valid_out,
        input  frame_done,
        output ready_in
    );

endinterface

// File: rtl/receive_pixel_uart_rx.sv
// UART byte receiver: 2-FF synchroniser, mid-bit sampling FSM, parity and stop checks.
module uart_rx
    import pixel_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50000000 / 115200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY_TYPE  = PARITY_NONE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(BITS_N - 1);

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q;
    logic             line;
    logic             line_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic             bit_tick;

    // Synchroniser resets low so a line already low after reset is not taken as a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            line_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_in};
            line_prev_q <= line;
        end
    end

    assign line = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_ok_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_ok_q <= par_ok_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        bit_tick   = (cnt_q == BIT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bit_d    = '0;
                par_ok_d = 1'b1;
                if (line_prev_q && !line)
                    state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[7:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == DATA_LAST)
                        state_d = (PARITY_TYPE != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_d    = '0;
                    par_ok_d = (PARITY_TYPE == PARITY_ODD) ? ((^shift_q) ^ line)
                                                           : !((^shift_q) ^ line);
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (line && par_ok_q)
                        byte_valid = 1'b1;
                    else
                        byte_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/receive_pixel.sv
// Pixel link receiver: pairs UART bytes into RGB444 pixels with frame addresses.
// Optional inter-byte timeout in LO phase is built when RX_BYTE_TIMEOUT_EN is defined.
module receive_pixel
    import pixel_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50000000 / 115200,
    parameter int unsigned BITS_N       = 8,
    parameter int unsigned PARITY_TYPE  = PARITY_NONE,
    parameter int unsigned IMAGE_SIZE   = 100,
    parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_in,
    receive_pixel_if.master pix_if,
    output logic            rx_error
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);

    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_err;
    asm_phase_t         phase_q, phase_d;
    logic [7:0]         hi_q;
    logic [PIXEL_W-1:0] pixel_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  cnt_q, cnt_next;
    logic               valid_q;
    logic               handshake;
    logic               pix_done;
    logic               can_load;
    logic               timeout;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BITS_N       (BITS_N),
        .PARITY_TYPE  (PARITY_TYPE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    assign handshake = valid_q && pix_if.ready_in;
    assign pix_done  = byte_valid && (phase_q == LO);
    assign can_load  = !valid_q || handshake;
    assign cnt_next  = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;

`ifdef RX_BYTE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt_q <= '0;
        else if (phase_q != LO)
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign timeout = (phase_q == LO) && !byte_valid && !byte_err &&
                     (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CLKS;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            phase_q <= HI;
        else
            phase_q <= phase_d;
    end

    // Any dropped byte or timeout realigns on the next byte as a high half.
    always_comb begin
        phase_d = phase_q;
        if (byte_err || timeout)
            phase_d = HI;
        else if (byte_valid)
            phase_d = (phase_q == HI) ? LO : HI;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q     <= '0;
            pixel_q  <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            if (byte_valid && (phase_q == HI))
                hi_q <= byte_data;

            // A pixel loaded in the handshake cycle takes the already-advanced address.
            if (pix_done && can_load) begin
                pixel_q <= {hi_q, byte_data[3:0]};
                addr_q  <= handshake ? cnt_next : cnt_q;
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            if (handshake)
                cnt_q <= cnt_next;

            if (byte_err || timeout || (pix_done && !can_load))
                rx_error <= 1'b1;
        end
    end

    assign pix_if.pixel      = pixel_q;
    assign pix_if.pixel_addr = addr_q;
    assign pix_if.valid_out  = valid_q;
    assign pix_if.frame_done = handshake && (addr_q == LAST_ADDR);

endmodule

// File: tb/tb_receive_pixel.sv
// Scoreboard bench for receive_pixel: UART byte driver, pair-to-pixel reference model, output monitor.
module tb_receive_pixel;
    import pixel_uart_pkg::*;

    localparam int unsigned CPB = 8;
    localparam int unsigned PAR = 2;
    localparam int unsigned IMG = 100;
    localparam int unsigned TMO = 20 * CPB;

    typedef struct packed {
        logic [11:0] pix;
        logic [16:0] addr;
    } exp_t;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic uart_in = 1'b1;
    logic rx_error;

    receive_pixel_if rp_if ();

    receive_pixel #(
        .CLKS_PER_BIT (CPB),
        .BITS_N       (8),
        .PARITY_TYPE  (PAR),
        .IMAGE_SIZE   (IMG),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_in  (uart_in),
        .pix_if   (rp_if),
        .rx_error (rx_error)
    );

    always #10 clk = ~clk;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_addr = 0;
    int unsigned fd_count = 0;
    int unsigned half_val = 0;
    bit          half_valid = 0;
    bit          exp_err = 0;
    bit          rand_ready = 0;
    bit          ready_req = 1;
    bit          hs_prev = 0;

    function automatic void chk(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Reference: good bytes pair up into pixels; any bad byte discards a pending half;
    // a pixel completing while the previous one is unconsumed is lost and flags an error.
    function automatic void model_byte(int unsigned data, int unsigned kind);
        exp_t e;
        if (kind != 0) begin
            exp_err    = 1;
            half_valid = 0;
        end else if (!half_valid) begin
            half_valid = 1;
            half_val   = data;
        end else begin
            half_valid = 0;
            if (exp_q.size() != 0) begin
                exp_err = 1;
            end else begin
                e.pix  = 12'((half_val * 16) + (data % 16));
                e.addr = 17'(exp_addr);
                exp_q.push_back(e);
                exp_addr = (exp_addr + 1) % IMG;
            end
        end
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        uart_in = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        uart_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // kind: 0 clean, 1 stop bit low, 2 wrong parity
    task automatic send_byte(input logic [7:0] data, input int unsigned kind);
        logic par;
        model_byte(data, kind);
        par = (PAR == 1) ? ~(^data) : (^data);
        if (kind == 2) par = ~par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (PAR != 0) drive_bit(par);
        drive_bit(kind != 1);
        @(negedge clk);
        uart_in = 1'b1;
    endtask

    task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0, 0);
        send_byte(b1, 0);
    endtask

    task automatic set_ready(input bit v);
        rand_ready = 0;
        ready_req  = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        half_valid = 0;
        exp_addr   = 0;
        exp_err    = 0;
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready)
            rp_if.ready_in = ($urandom_range(0, 3) != 0);
        else
            rp_if.ready_in = ready_req;
    end

    always @(negedge clk) begin
        exp_t e;
        if (hs_prev && exp_q.size() == 0)
            chk("valid_single_cycle", rp_if.valid_out, 0);
        hs_prev = 0;
        if (rp_if.frame_done) fd_count++;
        if (rst && rp_if.valid_out && rp_if.ready_in) begin
            hs_prev = 1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got %0h addr %0d expected none",
                         rp_if.pixel, rp_if.pixel_addr);
            end else begin
                e = exp_q.pop_front();
                chk("pixel", rp_if.pixel, e.pix);
                chk("pixel_addr", rp_if.pixel_addr, e.addr);
                chk("frame_done", rp_if.frame_done, (e.addr == 17'(IMG - 1)));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pixel", rp_if.pixel, 0);
        chk("rst_addr", rp_if.pixel_addr, 0);
        chk("rst_valid", rp_if.valid_out, 0);
        chk("rst_frame_done", rp_if.frame_done, 0);
        chk("rst_rx_error", rx_error, 0);
        rst = 1'b1;
        idle(4 * CPB);

        // first two pixels, always-ready sink
        send_pixel(8'hF0, 8'h0A);
        send_pixel(8'h5F, 8'h01);
        idle(3 * CPB);
        drain();
        chk("clean_rx_error", rx_error, exp_err);

        // random frame crossing the address wrap, random back-pressure
        rand_ready = 1;
        repeat (IMG) begin
            send_byte(8'($urandom), 0);
            idle($urandom_range(0, 6));
            send_byte(8'($urandom), 0);
            idle($urandom_range(0, 6));
        end
        idle(3 * CPB);
        set_ready(1);
        drain();
        chk("frame_done_count", fd_count, 1);
        chk("frame_rx_error", rx_error, exp_err);

        // overflow: sink stalled, second pixel lost
        assert_reset();
        release_reset();
        set_ready(0);
        send_pixel(8'h3C, 8'h07);
        send_pixel(8'h11, 8'h02);
        idle(3 * CPB);
        chk("hold_valid", rp_if.valid_out, 1);
        chk("hold_pixel", rp_if.pixel, 12'h3C7);
        chk("overflow_rx_error", rx_error, exp_err);
        set_ready(1);
        repeat (3) @(negedge clk);
        chk("addr_after_hs", rp_if.pixel_addr, 0);
        chk("valid_after_hs", rp_if.valid_out, 0);
        send_pixel(8'h44, 8'h05);
        idle(3 * CPB);
        drain();

        // framing error on byte 0
        assert_reset();
        release_reset();
        send_byte(8'h77, 1);
        send_pixel(8'h0F, 8'h03);
        idle(3 * CPB);
        drain();
        chk("stop_rx_error", rx_error, exp_err);

        // short glitch, then parity error on byte 1
        assert_reset();
        release_reset();
        @(negedge clk);
        uart_in = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_in = 1'b1;
        idle(3 * CPB);
        chk("glitch_rx_error", rx_error, 0);
        chk("glitch_valid", rp_if.valid_out, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 2);
        idle(3 * CPB);
        chk("parity_valid", rp_if.valid_out, 0);
        chk("parity_rx_error", rx_error, exp_err);
        send_pixel(8'h56, 8'h07);
        idle(3 * CPB);
        drain();

        // break: one framing error, then recovery
        assert_reset();
        release_reset();
        @(negedge clk);
        uart_in = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        uart_in    = 1'b1;
        exp_err    = 1;
        half_valid = 0;
        idle(2 * CPB);
        chk("break_valid", rp_if.valid_out, 0);
        send_pixel(8'hC3, 8'h09);
        idle(3 * CPB);
        drain();
        chk("break_rx_error", rx_error, exp_err);

        // long gap between the two bytes of a pixel
        assert_reset();
        release_reset();
`ifdef RX_BYTE_TIMEOUT_EN
        send_byte(8'h12, 0);
        idle(TMO + 1 + CPB);
        exp_err    = 1;
        half_valid = 0;
        chk("timeout_rx_error", rx_error, exp_err);
        send_pixel(8'hAB, 8'h0C);
`else
        send_byte(8'h12, 0);
        idle(TMO + 1 + CPB);
        chk("no_timeout_rx_error", rx_error, exp_err);
        send_byte(8'h05, 0);
`endif
        idle(3 * CPB);
        drain();

        // reset mid-pixel and mid-byte
        assert_reset();
        release_reset();
        set_ready(0);
        send_byte(8'h66, 1);
        send_pixel(8'h3C, 8'h05);
        send_byte(8'h81, 0);
        @(negedge clk);
        uart_in = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("pre_rst_valid", rp_if.valid_out, 1);
        chk("pre_rst_pixel", rp_if.pixel, 12'h3C5);
        chk("pre_rst_rx_error", rx_error, exp_err);
        assert_reset();
        #1;
        chk("mid_rst_pixel", rp_if.pixel, 0);
        chk("mid_rst_addr", rp_if.pixel_addr, 0);
        chk("mid_rst_valid", rp_if.valid_out, 0);
        chk("mid_rst_frame_done", rp_if.frame_done, 0);
        chk("mid_rst_rx_error", rx_error, 0);
        release_reset();
        set_ready(1);
        send_pixel(8'h9A, 8'h0B);
        idle(3 * CPB);
        drain();
        chk("final_rx_error", rx_error, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/receive_pixel.md
# receive_pixel

Receiving end of the FPGA-to-NANO pixel link. The block deserialises a UART stream (8N1 or 8-bit with parity), pairs consecutive bytes into 12-bit RGB444 pixels, and presents each pixel with its frame address on a valid/ready handshake. It sits between a GPIO RX pin and an image BRAM writer or a display pipeline.

## Interface
- CLKS_PER_BIT, 50000000/115200, clock cycles per UART bit
- BITS_N, 8, data bits per frame; only 8 is supported
- PARITY_TYPE, 0, 0 none, 1 odd, 2 even
- IMAGE_SIZE, 100, pixels per frame; the address wraps after IMAGE_SIZE-1
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, inter-byte timeout (only used with the macro)
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- uart_in  in  1  serial RX line, idle high, asynchronous to clk
- pixel  out  12  assembled pixel {R,G,B}
- pixel_addr  out  17  frame index of `pixel`, 0..IMAGE_SIZE-1
- valid_out  out  1  pixel/pixel_addr valid
- ready_in  in  1  downstream accepts when valid_out&&ready_in
- frame_done  out  1  one-cycle pulse on handshake of address IMAGE_SIZE-1
- rx_error  out  1  sticky: framing, parity, overflow or timeout seen; cleared only by rst

## Operation
- Pixel packing:
  - byte 0 = pixel[11:4].
  - byte 1 = {4'b0000, pixel[3:0]}.
  - byte 1 bits [7:4] are ignored.
  - Bytes are transmitted LSB first.
- RX state machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge of the synchronised line.
  - START waits CLKS_PER_BIT/2, then re-samples the line: low goes to DATA; high returns to IDLE as a glitch, with no error.
  - DATA samples BITS_N bits, each CLKS_PER_BIT apart.
  - After DATA, go to PARITY if PARITY_TYPE!=0, otherwise to STOP.
  - STOP samples the stop bit.
    - Stop bit 1 and parity OK: emit the byte.
    - Otherwise: drop the byte, set rx_error, and reset the assembler to HI phase.
  - STOP -> IDLE always.
- Assembler phases: HI, LO.
  - In HI, a byte is stored as pixel[11:4] -> LO.
  - In LO, a byte completes the pixel -> HI; the output register is loaded with pixel and the current address.
- Output register:
  - A single entry, held stable while valid_out && !ready_in.
  - If a pixel completes while the register is still full, the new pixel is dropped, rx_error is set, and the address does not advance.
- Address counter:
  - Increments on each handshake.
  - At IMAGE_SIZE-1 it wraps to 0 and pulses frame_done in the same cycle as the handshake.

## Timing
- uart_in passes through a 2-FF synchroniser before any use; this adds 2 cycles of detection delay.
- Mid-bit sampling: data bit k is sampled at CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT after the detected start edge. The stop bit follows at the next bit period.
- valid_out rises 1 cycle after the stop-bit sample of byte 1.
- Handshake:
  - Completes on a clk edge with valid_out && ready_in.
  - valid_out drops the next cycle unless a new pixel is loaded in that same cycle; in that case it stays high with the new data.
- Reset values: pixel=0, pixel_addr=0, valid_out=0, frame_done=0, rx_error=0. RX state = IDLE, assembler phase = HI, bit counters = 0.
- If rst is asserted mid-byte or mid-pixel, the partial byte or pixel is discarded. After release, the block waits for the line to be high in IDLE before it detects a new start edge.
- The line being held low (break) produces one framing error. No further bytes are received until the line returns high.

## Configuration
- RX_BYTE_TIMEOUT_EN defined:
  - In LO phase, a counter runs from the byte-0 stop sample.
  - If TIMEOUT_CLKS elapse without byte 1, the half pixel is discarded, the assembler returns to HI, and rx_error is set.
- RX_BYTE_TIMEOUT_EN undefined:
  - No timeout logic is built; LO phase waits indefinitely.
  - TIMEOUT_CLKS is unused.

## Structure
- Package pixel_uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP) and the asm_phase_t enum (HI, LO);
  - the PIXEL_W=12 and ADDR_W=17 constants;
  - the parity-type localparams.
- Sub-module uart_rx:
  - Contains the synchroniser, the RX state machine and the parity/stop checks.
  - Outputs byte_data[7:0], a byte_valid one-cycle pulse and a byte_err pulse.
- receive_pixel instantiates uart_rx and implements the assembler, the output register, the address counter and the timeout.

## Test plan
- Send bytes 0xF0, 0x0A with ready_in=1 -> pixel=12'hF0A, pixel_addr=0, valid_out high for 1 cycle; pixel 2 (0x5F, 0x01) -> 12'h5F1, addr=1.
- IMAGE_SIZE=100: stream 100 pixels -> frame_done pulses exactly once on pixel 99; the next pixel has addr=0; rx_error=0.
- With ready_in=0, receive 2 pixels -> the first is held; the second is dropped, rx_error=1, and addr is still 0 after the first handshake.
- Stop bit forced 0 on byte 0 -> byte dropped, rx_error=1; a following clean 0x0F, 0x03 yields 12'h0F3.
- 0.25-bit low glitch on the idle line -> no byte, no error. PARITY_TYPE=2 with wrong parity on byte 1 -> no pixel, rx_error=1.
- With RX_BYTE_TIMEOUT_EN, send byte 0x12 then idle for TIMEOUT_CLKS+1 -> rx_error=1; then 0xAB, 0x0C gives 12'hABC. Assert rst mid-byte -> all outputs return to reset values.
